// File: rtl/alu_pkg.sv
// Shared codes for the ALU decoder and the iterative multiply/divide unit.
package alu_pkg;

  // Main-decoder class for the EX stage
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  // ALU select codes
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  // R-type function codes
  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_SRA   = 6'b000011;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_XOR   = 6'b100110;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU  = 6'b101011;

  // MDU sequencer states
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} mdu_state_e;

  // Any HI/LO-related funct: mfhi/mthi/mflo/mtlo (0100xx) or mult/div (0110xx)
  function automatic logic is_mdu_funct(input logic [5:0] f);
    return (f[5:2] == 4'b0100) || (f[5:2] == 4'b0110);
  endfunction

  // Functs that launch an iterative operation; f[1] = divide, f[0] = unsigned
  function automatic logic is_muldiv_funct(input logic [5:0] f);
    return (f[5:2] == 4'b0110);
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// followed by one sign-correction cycle that commits the result to HI/LO.
module mdu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,       // [1] divide, [0] unsigned
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mdu_state_e state, state_nxt;

  logic [WIDTH-1:0] acc;       // product high half / partial remainder
  logic [WIDTH-1:0] quo;       // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] opnd;      // multiplicand or divisor magnitude
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             neg_lo;    // negate product / quotient in FIX
  logic             neg_hi;    // negate remainder in FIX
  logic             div_zero;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic                    sign_a, sign_b;
  logic [WIDTH-1:0]        mag_a, mag_b;

  logic [WIDTH:0]          shifted, add_x, add_y, sum;
  logic                    add_cin, div_ok;

  logic [2*WIDTH-1:0]      prod_fix;
  logic [WIDTH-1:0]        q_fix, r_fix;

  // Operand magnitudes for signed ops; unsigned ops pass straight through
  always_comb begin
    a_s    = src_a;
    b_s    = src_b;
    sign_a = ~op[0] & a_s[WIDTH-1];
    sign_b = ~op[0] & b_s[WIDTH-1];
    mag_a  = sign_a ? -src_a : src_a;
    mag_b  = sign_b ? -src_b : src_b;
  end

  // The single WIDTH+1-bit adder: add multiplicand, or trial-subtract divisor
  always_comb begin
    shifted = {acc, quo[WIDTH-1]};
    if (state == DIV) begin
      add_x   = shifted;
      add_y   = ~{1'b0, opnd};
      add_cin = 1'b1;
    end else begin
      add_x   = {1'b0, acc};
      add_y   = quo[0] ? {1'b0, opnd} : '0;
      add_cin = 1'b0;
    end
    sum    = add_x + add_y + {{WIDTH{1'b0}}, add_cin};
    // shifted < 2*divisor, so a set top bit always fits; else the sign decides
    div_ok = shifted[WIDTH] | ~sum[WIDTH];
  end

  // Sign correction and divide-by-zero override applied in FIX
  always_comb begin
    prod_fix = neg_lo ? -{acc, quo} : {acc, quo};
    q_fix    = div_zero ? '1 : (neg_lo ? -quo : quo);
    r_fix    = neg_hi ? -acc : acc;
  end

  // Sequencer next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = op[1] ? DIV : MUL;
      MUL,
      DIV:     if (cnt == '0) state_nxt = FIX;
      default: state_nxt = IDLE;
    endcase
  end

  // State, iteration registers and architectural HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      quo      <= '0;
      opnd     <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == FIX);
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            quo      <= mag_a;
            opnd     <= mag_b;
            cnt      <= CNT_W'(WIDTH - 1);
            is_div   <= op[1];
            neg_lo   <= sign_a ^ sign_b;
            neg_hi   <= sign_a;
            div_zero <= (src_b == '0);
          end
          if (wr_hi) hi <= wr_data;
          if (wr_lo) lo <= wr_data;
        end
        MUL: begin
          acc <= sum[WIDTH:1];
          quo <= {sum[0], quo[WIDTH-1:1]};
          cnt <= cnt - 1'b1;
        end
        DIV: begin
          acc <= div_ok ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], div_ok};
          cnt <= cnt - 1'b1;
        end
        default: begin
          if (is_div) begin
            hi <= r_fix;
            lo <= q_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/alu_mdu_control.sv
// EX-stage ALU control: decodes alu_op/funct into an ALU select, routes
// HI/LO moves, launches the iterative MDU and stalls HI/LO users while busy.
module alu_mdu_control
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic             valid,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [SEL_W-1:0] select,
  output logic             illegal,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             use_hilo,
  output logic [WIDTH-1:0] hilo_result
);

  logic [3:0] sel_code;
  logic       r_type, mdu_instr, start, wr_hi, wr_lo;

  // ALU operation decode
  always_comb begin
    sel_code = ALU_AND;
    illegal  = 1'b0;
    case (alu_op)
      ALUOP_ADD: sel_code = ALU_ADD;
      ALUOP_SUB: sel_code = ALU_SUB;
      ALUOP_OR:  sel_code = ALU_OR;
      default: begin
        casez (funct)
          6'b10000?:   sel_code = ALU_ADD;
          6'b10001?:   sel_code = ALU_SUB;
          FUNCT_AND:   sel_code = ALU_AND;
          FUNCT_OR:    sel_code = ALU_OR;
          FUNCT_XOR:   sel_code = ALU_XOR;
          FUNCT_NOR:   sel_code = ALU_NOR;
          FUNCT_SLT:   sel_code = ALU_SLT;
          FUNCT_SLTU:  sel_code = ALU_SLTU;
          FUNCT_SLL:   sel_code = ALU_SLL;
          FUNCT_SRL:   sel_code = ALU_SRL;
          FUNCT_SRA:   sel_code = ALU_SRA;
          default: begin
            if (is_mdu_funct(funct)) sel_code = ALU_ADD;
            else                     illegal  = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign select = SEL_W'(sel_code);

  // HI/LO instruction handling: stall while the MDU is occupied
  always_comb begin
    r_type      = valid & (alu_op == ALUOP_RTYPE);
    mdu_instr   = r_type & is_mdu_funct(funct);
    stall       = busy & mdu_instr;
    start       = mdu_instr & is_muldiv_funct(funct) & ~busy & ~reset;
    wr_hi       = r_type & (funct == FUNCT_MTHI) & ~busy & ~reset;
    wr_lo       = r_type & (funct == FUNCT_MTLO) & ~busy & ~reset;
    use_hilo    = r_type & ((funct == FUNCT_MFHI) | (funct == FUNCT_MFLO));
    hilo_result = '0;
    if (use_hilo & ~stall) hilo_result = (funct == FUNCT_MFHI) ? hi : lo;
  end

  mdu_core #(
    .WIDTH (WIDTH)
  ) u_mdu_core (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (funct[1:0]),
    .src_a   (src_a),
    .src_b   (src_b),
    .wr_hi   (wr_hi),
    .wr_lo   (wr_lo),
    .wr_data (src_a),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done)
  );

endmodule

// File: tb/tb_alu_mdu_control.sv
// Directed self-checking bench for alu_mdu_control (WIDTH=32).
module tb_alu_mdu_control;

  localparam int WIDTH = 32;
  localparam int SEL_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic             valid;
  logic [WIDTH-1:0] src_a, src_b;
  logic [SEL_W-1:0] select;
  logic             illegal, stall, busy, done, use_hilo;
  logic [WIDTH-1:0] hi, lo, hilo_result;

  int pass_cnt  = 0;
  int total_cnt = 0;

  alu_mdu_control #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_op      (alu_op),
    .funct       (funct),
    .valid       (valid),
    .src_a       (src_a),
    .src_b       (src_b),
    .select      (select),
    .illegal     (illegal),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .use_hilo    (use_hilo),
    .hilo_result (hilo_result)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid  = 1'b0;
    alu_op = 2'b00;
    funct  = 6'h00;
    src_a  = '0;
    src_b  = '0;
  endtask

  // Reference decode table: {illegal, select}
  function automatic logic [4:0] exp_dec(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 5'b0_0010;
    if (op == 2'b01) return 5'b0_0110;
    if (op == 2'b11) return 5'b0_0001;
    case (f)
      6'h20, 6'h21: return 5'b0_0010;
      6'h22, 6'h23: return 5'b0_0110;
      6'h24:        return 5'b0_0000;
      6'h25:        return 5'b0_0001;
      6'h26:        return 5'b0_0011;
      6'h27:        return 5'b0_1100;
      6'h2A:        return 5'b0_0111;
      6'h2B:        return 5'b0_1111;
      6'h00:        return 5'b0_1000;
      6'h02:        return 5'b0_1001;
      6'h03:        return 5'b0_1010;
      6'h10, 6'h11, 6'h12, 6'h13,
      6'h18, 6'h19, 6'h1A, 6'h1B: return 5'b0_0010;
      default:      return 5'b1_0000;
    endcase
  endfunction

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({hi, lo} !== 64'h0) $display("FAIL reset_hilo: got %h expected 0", {hi, lo});
    else pass_cnt++;
    total_cnt++;
    if ({busy, done, stall} !== 3'b000) $display("FAIL reset_ctrl: got busy/done/stall %b expected 000", {busy, done, stall});
    else pass_cnt++;
    step();
  endtask

  task automatic test_decode();
    logic [4:0] exp;
    idle_inputs();
    for (int op = 0; op < 4; op++) begin
      for (int f = 0; f < 64; f++) begin
        alu_op = op[1:0];
        funct  = f[5:0];
        #1;
        exp = exp_dec(op[1:0], f[5:0]);
        total_cnt++;
        if ({illegal, select} !== exp)
          $display("FAIL decode op=%b funct=%b: got ill/sel %b expected %b", op[1:0], f[5:0], {illegal, select}, exp);
        else pass_cnt++;
      end
    end
    alu_op = 2'b10;
    funct  = 6'b111111;
    #1;
    total_cnt++;
    if ({illegal, select} !== 5'b1_0000) $display("FAIL decode_3f: got %b expected 10000", {illegal, select});
    else pass_cnt++;
    // An illegal funct with valid must not launch the MDU
    valid = 1'b1;
    step();
    valid = 1'b0;
    #1;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL illegal_no_start: got busy %b expected 0", busy);
    else pass_cnt++;
    idle_inputs();
    step();
  endtask

  // Issue one mult/div in IDLE and check timing and the committed HI/LO
  task automatic do_mdu_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
    valid  = 1'b1;
    alu_op = 2'b10;
    funct  = f;
    src_a  = a;
    src_b  = b;
    step();
    idle_inputs();
    for (int i = 0; i < 32; i++) step();
    total_cnt++;
    if ({busy, done} !== 2'b10) $display("FAIL %s_fix: got busy/done %b expected 10", name, {busy, done});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({hi, lo} !== {exp_hi, exp_lo}) $display("FAIL %s_result: got hi/lo %h expected %h", name, {hi, lo}, {exp_hi, exp_lo});
    else pass_cnt++;
    total_cnt++;
    if ({busy, done} !== 2'b01) $display("FAIL %s_done: got busy/done %b expected 01", name, {busy, done});
    else pass_cnt++;
    step();
    total_cnt++;
    if (done !== 1'b0) $display("FAIL %s_done_pulse: got done %b expected 0", name, done);
    else pass_cnt++;
  endtask

  task automatic test_mult();
    do_mdu_op(6'h18, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult");
    do_mdu_op(6'h19, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, "multu");
    do_mdu_op(6'h18, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, "mult_negneg");
    do_mdu_op(6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minmin");
  endtask

  task automatic test_div();
    do_mdu_op(6'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7_2");
    do_mdu_op(6'h1A, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7_neg2");
    do_mdu_op(6'h1B, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, "divu_by0");
    do_mdu_op(6'h1A, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_by0");
    do_mdu_op(6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_min_m1");
    do_mdu_op(6'h1B, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, "divu_big");
  endtask

  task automatic test_stall();
    valid  = 1'b1;
    alu_op = 2'b10;
    funct  = 6'h18;
    src_a  = 32'd5;
    src_b  = 32'd7;
    step();
    for (int c = 0; c < 33; c++) begin
      funct = (c == 5) ? 6'h20 : 6'h12;
      #1;
      total_cnt++;
      if (stall !== (c != 5)) $display("FAIL stall_cycle%0d: got %b expected %b", c, stall, (c != 5));
      else pass_cnt++;
      if (c == 5) begin
        total_cnt++;
        if (select !== 4'b0010) $display("FAIL add_while_busy_sel: got %b expected 0010", select);
        else pass_cnt++;
      end
      if (c == 1) begin
        total_cnt++;
        if ({use_hilo, hilo_result} !== {1'b1, 32'h0}) $display("FAIL stalled_mflo: got %h expected 100000000", {use_hilo, hilo_result});
        else pass_cnt++;
      end
      step();
    end
    #1;
    total_cnt++;
    if ({stall, done} !== 2'b01) $display("FAIL stall_release: got stall/done %b expected 01", {stall, done});
    else pass_cnt++;
    total_cnt++;
    if ({use_hilo, hilo_result} !== {1'b1, 32'd35}) $display("FAIL mflo_after_done: got %h expected 100000023", {use_hilo, hilo_result});
    else pass_cnt++;
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    int bad;
    valid  = 1'b1;
    alu_op = 2'b10;
    funct  = 6'h18;
    src_a  = 32'd3;
    src_b  = 32'd4;
    step();
    funct = 6'h1B;
    src_a = 32'd20;
    src_b = 32'd6;
    bad = 0;
    for (int c = 0; c < 33; c++) begin
      if (stall !== 1'b1) bad++;
      step();
    end
    total_cnt++;
    if (bad != 0) $display("FAIL b2b_stall: got %0d unstalled cycles expected 0", bad);
    else pass_cnt++;
    total_cnt++;
    if ({stall, done, hi, lo} !== {2'b01, 32'd0, 32'd12}) $display("FAIL b2b_first: got %h expected %h", {stall, done, hi, lo}, {2'b01, 32'd0, 32'd12});
    else pass_cnt++;
    step();
    idle_inputs();
    #1;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL b2b_accept: got busy %b expected 1", busy);
    else pass_cnt++;
    for (int i = 0; i < 33; i++) step();
    total_cnt++;
    if ({done, hi, lo} !== {1'b1, 32'd2, 32'd3}) $display("FAIL b2b_second: got %h expected %h", {done, hi, lo}, {1'b1, 32'd2, 32'd3});
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid();
    int dones;
    valid  = 1'b1;
    alu_op = 2'b10;
    funct  = 6'h1A;
    src_a  = 32'd100;
    src_b  = 32'd7;
    step();
    idle_inputs();
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, hi, lo} !== 66'h0) $display("FAIL reset_mid: got busy/done/hi/lo %h expected 0", {busy, done, hi, lo});
    else pass_cnt++;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0) dones++;
      step();
    end
    total_cnt++;
    if (dones != 0 || {hi, lo} !== 64'h0) $display("FAIL reset_mid_after: got %0d done pulses hi/lo %h expected 0", dones, {hi, lo});
    else pass_cnt++;
    // Reset dominates a simultaneous mthi and a simultaneous mult start
    reset  = 1'b1;
    valid  = 1'b1;
    alu_op = 2'b10;
    funct  = 6'h11;
    src_a  = 32'h55;
    step();
    funct = 6'h18;
    step();
    reset = 1'b0;
    idle_inputs();
    #1;
    total_cnt++;
    if ({busy, hi} !== 33'h0) $display("FAIL reset_dominates: got busy/hi %h expected 0", {busy, hi});
    else pass_cnt++;
    step();
  endtask

  task automatic test_mthi_mfhi();
    valid  = 1'b1;
    alu_op = 2'b10;
    funct  = 6'h13;
    src_a  = 32'h0000ABCD;
    step();
    funct = 6'h11;
    src_a = 32'h00001234;
    step();
    idle_inputs();
    #1;
    total_cnt++;
    if ({hi, lo} !== {32'h1234, 32'hABCD}) $display("FAIL mthi_mtlo: got %h expected 00001234_0000abcd", {hi, lo});
    else pass_cnt++;
    valid  = 1'b1;
    alu_op = 2'b10;
    funct  = 6'h12;
    #1;
    total_cnt++;
    if ({stall, use_hilo, hilo_result} !== {2'b01, 32'hABCD}) $display("FAIL mflo_idle: got %h expected %h", {stall, use_hilo, hilo_result}, {2'b01, 32'hABCD});
    else pass_cnt++;
    funct = 6'h10;
    #1;
    total_cnt++;
    if ({stall, use_hilo, hilo_result} !== {2'b01, 32'h1234}) $display("FAIL mfhi_idle: got %h expected %h", {stall, use_hilo, hilo_result}, {2'b01, 32'h1234});
    else pass_cnt++;
    valid = 1'b0;
    #1;
    total_cnt++;
    if ({use_hilo, hilo_result} !== 33'h0) $display("FAIL mfhi_novalid: got %h expected 0", {use_hilo, hilo_result});
    else pass_cnt++;
    idle_inputs();
    step();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_decode();
    test_mult();
    test_div();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_mthi_mfhi();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_mdu_control.md
ALU_MDU_CONTROL -- requirements
Module: alu_mdu_control

Interface
REQ-001 Parameter WIDTH, default 32, operand/HI/LO width (even, >=8) SHALL be supported.
REQ-002 Parameter SEL_W, default 4, ALU select width SHALL be supported.
REQ-003 Ports SHALL be: clk in 1 (rising-edge clock); reset in 1 (synchronous, active-high).
REQ-004 Inputs: alu_op 2 (main-decoder class); funct 6 (R-type function); valid 1 (EX-stage instruction present); src_a WIDTH; src_b WIDTH.
REQ-005 Outputs: select SEL_W (ALU operation); illegal 1 (undecodable op); stall 1 (hold pipeline); busy 1 (MDU iterating); done 1 (one-cycle completion pulse).
REQ-006 Outputs: hi WIDTH, lo WIDTH (architectural HI/LO); use_hilo 1 (EX result is hilo_result); hilo_result WIDTH (mfhi/mflo data).
REQ-007 One clock domain (clk) and synchronous active-high reset SHALL be used throughout.

Function
REQ-010 select/illegal SHALL be combinational from alu_op, funct.
REQ-011 alu_op 00->0010 add; 01->0110 sub; 11->0001 or.
REQ-012 alu_op 10: add/addu 10000x->0010; sub/subu 10001x->0110; and 100100->0000; or 100101->0001; xor 100110->0011; nor 100111->1100; slt 101010->0111; sltu 101011->1111; sll 000000->1000; srl 000010->1001; sra 000011->1010.
REQ-013 alu_op 10 with MDU functs (mfhi 010000, mthi 010001, mflo 010010, mtlo 010011, mult 011000, multu 011001, div 011010, divu 011011) SHALL give select 0010, illegal 0.
REQ-014 Any other funct SHALL give select 0000, illegal 1; illegal never starts the MDU.
REQ-015 States: IDLE, MUL, DIV, FIX.
REQ-016 Start: valid & alu_op==10 & MDU mult/div funct & state IDLE & !reset; operands latched at that edge; IDLE->MUL (mult*) or DIV (div*).
REQ-017 MUL and DIV SHALL each run exactly WIDTH cycles (radix-2 shift-add / restoring), then FIX for one cycle, then IDLE.
REQ-018 Signed ops SHALL operate on magnitudes with sign correction in FIX; quotient sign = sign_a^sign_b, remainder sign = sign_a.
REQ-019 HI/LO SHALL update at end of FIX; done high exactly that next cycle; start-to-HI/LO-visible latency WIDTH+2 edges.
REQ-020 mult*: {hi,lo} = full 2*WIDTH product; div*: lo = quotient, hi = remainder.
REQ-021 Divide by zero: lo = all ones, hi = src_a, same latency, no error flag.
REQ-022 Signed MIN / -1: lo = MIN, hi = 0.
REQ-023 busy SHALL be high in MUL, DIV, FIX; low in IDLE.
REQ-024 stall SHALL be combinational: busy & valid & alu_op==10 & funct is any MDU funct.
REQ-025 Non-MDU instructions SHALL proceed without stall while busy.
REQ-026 mthi/mtlo with valid in IDLE SHALL write src_a to hi/lo at next edge.
REQ-027 mfhi/mflo with valid: use_hilo=1, hilo_result = hi/lo; when stalled, use_hilo=1 and hilo_result undefined-but-stable-zero (0).
REQ-028 Stalled MDU instruction SHALL be accepted in the first IDLE cycle it is presented (after done).

Reset
REQ-030 On reset edge: state IDLE, hi=0, lo=0, busy=0, done=0, internal accumulators 0.
REQ-031 Reset mid-operation SHALL abort; partial result SHALL never reach hi/lo.
REQ-032 Reset dominates simultaneous start, mthi/mtlo.

Structure
REQ-040 Shared package alu_pkg SHALL hold ALU select codes, funct codes, alu_op codes, MDU state enum.
REQ-041 Iterative datapath SHALL be sub-module mdu_core (operands, op, start in; hi, lo, done out); decode and stall logic in the top.
REQ-042 No multiplier/divider operators; one adder/subtractor of WIDTH+1 bits in mdu_core.

Verification
REQ-050 Decode sweep: every alu_op/funct pair -> select/illegal per REQ-011..014; funct 111111 -> illegal 1, select 0000.
REQ-051 mult 0xFFFFFFFE x 0x00000003 -> after 34 edges hi=0xFFFFFFFF, lo=0xFFFFFFFA; multu same -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-052 div -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/0 -> lo=0xFFFFFFFF, hi=7; div 0x80000000/-1 -> lo=0x80000000, hi=0.
REQ-053 mflo issued 1 cycle after mult start -> stall high until done cycle, then lo read correctly; add issued meanwhile -> no stall.
REQ-054 Reset asserted at iteration 10 of div -> next cycle busy=0, hi=lo=0, no done pulse.
REQ-055 mthi 0x1234 then mflo/mfhi in IDLE -> hi=0x1234 next cycle, hilo_result=0x1234, no stall.
